// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: opcodes and FSM states shared by the arbiter and its logic unit
package logic_unit_arbiter_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// logic_unit: combinational bitwise AND/OR/XOR/NOR over WIDTH bits
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb y = (op == OP_AND) ? (a & b) :
                  (op == OP_OR)  ? (a | b) :
                  (op == OP_XOR) ? (a ^ b) : ~(a | b);
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one logic unit; define LUA_PRIO0_EN to give requester 0 fixed priority
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]     req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id
);
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, resp_id_q, resp_id_d;
  logic [ID_W-1:0] gnt, idx, id_inc;
  logic [ID_W:0] sum;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y, resp_data_q, resp_data_d;
  logic [1:0] op_q, op_d;
  logic resp_valid_q, resp_valid_d, found;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [1:0] op_arr [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign op_arr[i] = req_op[i*2 +: 2];
  end
  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .a (a_q),
    .b (b_q),
    .op(op_q),
    .y (y)
  );
  // Search starts at rr_ptr and wraps modulo N_REQ.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      idx = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
`ifdef LUA_PRIO0_EN
      if (!found && req_valid[idx] && idx != '0) begin
`else
      if (!found && req_valid[idx]) begin
`endif
        found = 1'b1;
        gnt = idx;
      end
    end
`ifdef LUA_PRIO0_EN
    if (req_valid[0]) begin
      found = 1'b1;
      gnt = '0;
    end
`endif
  end
  assign id_inc = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    resp_valid_d = resp_valid_q;
    resp_data_d = resp_data_q;
    resp_id_d = resp_id_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: if (found) begin
        req_ready[gnt] = ~rst;
        a_d = a_arr[gnt];
        b_d = b_arr[gnt];
        op_d = op_arr[gnt];
        id_d = gnt;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        resp_data_d = y;
        resp_id_d = id_q;
        resp_valid_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
`ifdef LUA_PRIO0_EN
        rr_ptr_d = (id_q != '0) ? id_inc : rr_ptr_q;
`else
        rr_ptr_d = id_inc;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q <= '0;
      resp_id_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q <= resp_data_d;
      resp_id_q <= resp_id_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign resp_id = resp_id_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized self-checking bench with a spec-level reference model
module tb_logic_unit_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_REQ-1:0] req_valid = '0;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*WIDTH-1:0] req_a = '0;
  logic [N_REQ*WIDTH-1:0] req_b = '0;
  logic [N_REQ*2-1:0] req_op = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_data;
  logic [ID_W-1:0] resp_id;
  int n_cmp = 0;
  int n_err = 0;
  int rr = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_id(resp_id)
  );
  function automatic logic [WIDTH-1:0] ref_lu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction
  function automatic int ref_grant(input logic [N_REQ-1:0] v, input int ptr);
`ifdef LUA_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction
  function automatic logic [WIDTH-1:0] lane_a(input int i);
    return req_a[i*WIDTH +: WIDTH];
  endfunction
  function automatic logic [WIDTH-1:0] lane_b(input int i);
    return req_b[i*WIDTH +: WIDTH];
  endfunction
  function automatic logic [1:0] lane_op(input int i);
    return req_op[i*2 +: 2];
  endfunction
  task automatic model_done(input int g);
`ifdef LUA_PRIO0_EN
    if (g != 0) rr = (g + 1) % N_REQ;
`else
    rr = (g + 1) % N_REQ;
`endif
  endtask
  task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2] = op;
  endtask
  task automatic randomize_lanes;
    for (int i = 0; i < N_REQ; i++)
      set_lane(i, WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
  endtask
  task automatic wait_ready(output int lane, output bit ok);
    ok = 1'b0;
    lane = -1;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (|req_ready) begin
        ok = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) lane = i;
      end else @(negedge clk);
    end
  endtask
  task automatic wait_resp(output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    while (!ok && c < 40) begin
      #1;
      if (resp_valid === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
  endtask
  task automatic test_reset;
    int c;
    bit ok;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h id=%0d, want all zero", req_ready, resp_valid, resp_data, resp_id);
    end
    rst = 1'b0;
    rr = 0;
    set_lane(1, 8'h5A, 8'h33, 2'd2);
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_first_grant: ready=%b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(c, ok);
    n_cmp++;
    if (!ok || resp_data !== 8'h69 || resp_id !== 2'd1) begin
      n_err++;
      $display("FAIL reset_pre_op: ok=%0d data=%h id=%0d want 69/1", ok, resp_data, resp_id);
    end
    model_done(1);
    @(negedge clk);
    set_lane(3, 8'hC3, 8'h81, 2'd0);
    req_valid = 4'b1000;
    @(negedge clk);
    set_lane(2, 8'h12, 8'h34, 2'd1);
    req_valid = 4'b1100;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== '0) begin
      n_err++;
      $display("FAIL reset_mid_exec: ready=%b valid=%b data=%h id=%0d, want all zero", req_ready, resp_valid, resp_data, resp_id);
    end
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_regrant: ready=%b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(c, ok);
    n_cmp++;
    if (!ok || c != 1 || resp_data !== 8'h36 || resp_id !== 2'd2) begin
      n_err++;
      $display("FAIL reset_post_op: ok=%0d lat=%0d data=%h id=%0d want 1/36/2", ok, c, resp_data, resp_id);
    end
    model_done(2);
  endtask
  task automatic test_single;
    do_reset;
    resp_ready = 1'b1;
    set_lane(2, 8'hF0, 8'h3C, 2'b01);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant: ready=%b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_exec: ready=%b valid=%b want 0000/0", req_ready, resp_valid);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hFC || resp_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_resp: valid=%b data=%h id=%0d want 1/fc/2", resp_valid, resp_data, resp_id);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: valid=%b want 0", resp_valid);
    end
  endtask
  task automatic test_opcodes;
    logic [WIDTH-1:0] exp_tbl [4];
    int g, c;
    bit ok;
    exp_tbl = '{8'h0A, 8'hAF, 8'hA5, 8'h50};
    do_reset;
    resp_ready = 1'b1;
    for (int o = 0; o < 4; o++) begin
      set_lane(0, 8'hAA, 8'h0F, 2'(o));
      req_valid = 4'b0001;
      wait_ready(g, ok);
      n_cmp++;
      if (!ok || g != 0) begin
        n_err++;
        $display("FAIL opcode_grant[%0d]: ok=%0d lane=%0d want 0", o, ok, g);
      end
      @(negedge clk);
      req_valid = '0;
      wait_resp(c, ok);
      n_cmp++;
      if (!ok || resp_data !== exp_tbl[o] || resp_id !== 2'd0) begin
        n_err++;
        $display("FAIL opcode_result[%0d]: ok=%0d data=%h id=%0d want %h/0", o, ok, resp_data, resp_id, exp_tbl[o]);
      end
      model_done(0);
      @(negedge clk);
    end
  endtask
  task automatic test_fairness;
    int g, c, g_exp, t_prev;
    bit ok;
    logic [WIDTH-1:0] d_exp;
    do_reset;
    resp_ready = 1'b1;
    randomize_lanes;
    req_valid = '1;
    t_prev = 0;
    for (int n = 0; n < 5; n++) begin
      g_exp = ref_grant(req_valid, rr);
      wait_ready(g, ok);
      n_cmp++;
      if (!ok || g != g_exp || req_ready !== N_REQ'(1 << g_exp)) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: ready=%b want lane %0d", n, req_ready, g_exp);
      end
      if (n > 0) begin
        n_cmp++;
        if (cyc - t_prev != 3) begin
          n_err++;
          $display("FAIL fair_spacing[%0d]: %0d cycles want 3", n, cyc - t_prev);
        end
      end
      t_prev = cyc;
      d_exp = ref_lu(lane_a(g_exp), lane_b(g_exp), lane_op(g_exp));
      @(negedge clk);
      wait_resp(c, ok);
      n_cmp++;
      if (!ok || c != 1 || resp_data !== d_exp || resp_id !== ID_W'(g_exp)) begin
        n_err++;
        $display("FAIL fair_resp[%0d]: lat=%0d data=%h id=%0d want 1/%h/%0d", n, c, resp_data, resp_id, d_exp, g_exp);
      end
      model_done(g_exp);
      @(negedge clk);
    end
    req_valid = '0;
  endtask
  task automatic test_backpressure;
    int g, c;
    bit ok;
    logic [WIDTH-1:0] d_exp;
    do_reset;
    randomize_lanes;
    req_valid = 4'b1000;
    wait_ready(g, ok);
    n_cmp++;
    if (!ok || g != 3) begin
      n_err++;
      $display("FAIL bp_grant: ok=%0d lane=%0d want 3", ok, g);
    end
    d_exp = ref_lu(lane_a(3), lane_b(3), lane_op(3));
    @(negedge clk);
    req_valid = 4'b0111;
    wait_resp(c, ok);
    n_cmp++;
    if (!ok || resp_data !== d_exp || resp_id !== 2'd3) begin
      n_err++;
      $display("FAIL bp_resp: ok=%0d data=%h id=%0d want %h/3", ok, resp_data, resp_id, d_exp);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== d_exp || resp_id !== 2'd3 || req_ready !== '0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d ready=%b want 1/%h/3/0000", k, resp_valid, resp_data, resp_id, req_ready, d_exp);
      end
    end
    resp_ready = 1'b1;
    model_done(3);
    @(negedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== N_REQ'(1 << ref_grant(4'b0111, rr))) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ready=%b want 0/lane %0d", resp_valid, req_ready, ref_grant(4'b0111, rr));
    end
    req_valid = '0;
  endtask
  task automatic test_prio;
    int g, c, g_exp;
    bit ok;
    do_reset;
    resp_ready = 1'b1;
    randomize_lanes;
    req_valid = 4'b1001;
    for (int n = 0; n < 4; n++) begin
`ifdef LUA_PRIO0_EN
      g_exp = 0;
`else
      g_exp = (n % 2 == 0) ? 0 : 3;
`endif
      wait_ready(g, ok);
      n_cmp++;
      if (!ok || g != g_exp) begin
        n_err++;
        $display("FAIL prio_grant[%0d]: ok=%0d lane=%0d want %0d", n, ok, g, g_exp);
      end
      @(negedge clk);
      wait_resp(c, ok);
      n_cmp++;
      if (!ok || resp_id !== ID_W'(g_exp)) begin
        n_err++;
        $display("FAIL prio_resp[%0d]: ok=%0d id=%0d want %0d", n, ok, resp_id, g_exp);
      end
      model_done(g_exp);
      @(negedge clk);
    end
    req_valid = '0;
  endtask
  task automatic test_random;
    int g, c, g_exp, d;
    bit ok;
    logic [WIDTH-1:0] d_exp;
    logic [N_REQ-1:0] mask;
    do_reset;
    for (int n = 0; n < 40; n++) begin
      randomize_lanes;
      mask = N_REQ'($urandom);
      if (mask == '0) begin
        req_valid = '0;
        #1;
        n_cmp++;
        if (req_ready !== '0) begin
          n_err++;
          $display("FAIL rnd_idle[%0d]: ready=%b want 0000", n, req_ready);
        end
        @(negedge clk);
        mask = N_REQ'(1) << $urandom_range(0, N_REQ-1);
      end
      req_valid = mask;
      g_exp = ref_grant(mask, rr);
      wait_ready(g, ok);
      n_cmp++;
      if (!ok || g != g_exp || req_ready !== N_REQ'(1 << g_exp)) begin
        n_err++;
        $display("FAIL rnd_grant[%0d]: mask=%b rr=%0d ready=%b want lane %0d", n, mask, rr, req_ready, g_exp);
      end
      d_exp = ref_lu(lane_a(g_exp), lane_b(g_exp), lane_op(g_exp));
      @(negedge clk);
      randomize_lanes;
      req_valid = N_REQ'($urandom);
      wait_resp(c, ok);
      n_cmp++;
      if (!ok || c != 1 || resp_data !== d_exp || resp_id !== ID_W'(g_exp)) begin
        n_err++;
        $display("FAIL rnd_resp[%0d]: lat=%0d data=%h id=%0d want 1/%h/%0d", n, c, resp_data, resp_id, d_exp, g_exp);
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        #1;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== d_exp || req_ready !== '0) begin
          n_err++;
          $display("FAIL rnd_hold[%0d]: valid=%b data=%h ready=%b want 1/%h/0000", n, resp_valid, resp_data, req_ready, d_exp);
        end
      end
      resp_ready = 1'b1;
      model_done(g_exp);
      @(negedge clk);
      resp_ready = 1'b0;
    end
    req_valid = '0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_opcodes;
    test_fairness;
    test_backpressure;
    test_prio;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
